conv_collect: RTL
=================

# conv_collect

Result collector on the receiving side of the conv pixel handshake. It accepts each `out_pixel`/`addr` pair the conv engine presents with `valid` or `done`. It accumulates the pair into a local result buffer, either overwriting on the first input channel or adding on later channels, then acknowledges with a one-cycle `save_done` pulse. After the frame it serves a requantized 8-bit read port that feeds the next layer or the FC stage.

## Interface

- `ACC_W`, 28: stored accumulator width (signed); holds 24-bit conv sums over up to 16 channels.
- `PIX_W`, 24: width of incoming `out_pixel` (signed).
- `DEPTH`, 256: buffer entries; indexed by 8-bit `addr`.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid`  in  1  conv has a pixel on `out_pixel`/`addr`; held until acknowledged.
- `done`  in  1  conv presents the final pixel of the frame; same data semantics as `valid`.
- `out_pixel`  in  24  signed conv result.
- `addr`  in  8  linear output index (row*out_w + col).
- `first_chan`  in  1  1: overwrite entry; 0: add to stored entry. Sampled at capture.
- `relu_en`  in  1  ReLU applied on the read path.
- `shift`  in  5  arithmetic right-shift applied on the read path.
- `save_done`  out  1  one-cycle acknowledge per captured pixel.
- `busy`  out  1  capture sequence in progress (state ≠ IDLE).
- `frame_done`  out  1  sticky; set when the `done` pixel is written.
- `frame_clr`  in  1  clears `frame_done`.
- `rd_en`  in  1  read request.
- `rd_addr`  in  8  read index.
- `rd_valid`  out  1  `rd_data`/`rd_raw` valid.
- `rd_data`  out  8  requantized unsigned result.
- `rd_raw`  out  28  stored signed accumulator.

## Operation

- FSM states are IDLE, READ, WRITE, ACK and RELEASE.
- IDLE: when `valid|done` is high, capture `out_pixel`, `addr`, `first_chan` and `done` into registers, then go to READ.
- READ: issue a buffer read at the captured address, then go to WRITE.
- WRITE:
  - sum = `first_chan` ? sext(pixel) : stored + sext(pixel).
  - The sum saturates to the signed ACC_W range: max 2^27−1, min −2^27.
  - Write the sum. If the captured `done` is set, set `frame_done`.
  - Go to ACK.
- ACK: `save_done`=1 for exactly this cycle, then go to RELEASE.
- RELEASE: wait until `valid`=0 and `done`=0, then go to IDLE. This prevents a held `valid` from being captured twice.
- The `done` pixel is stored and acknowledged like any other pixel.
- Read path:
  - Reads are accepted only when `busy`=0. `rd_en` while busy is ignored, and `rd_valid` stays 0.
  - v = stored entry; if `relu_en` and v<0 then v=0; v = v >>> `shift`.
  - `rd_data` = v saturated to [0,255]. Negative values, possible only when `relu_en`=0, give 0.
  - `rd_raw` = stored entry, unmodified.
- `frame_clr` and a `frame_done` set in the same cycle: set wins.
- Buffer contents are not initialised by reset. The first channel must run with `first_chan`=1.

## Timing

- Reset values:
  - state=IDLE.
  - `save_done`=0, `busy`=0, `frame_done`=0.
  - `rd_valid`=0, `rd_data`=0, `rd_raw`=0.
  - Buffer contents are unchanged.
- Capture cycle C0 = the first edge in IDLE with `valid|done`=1.
  - READ at C1, WRITE at C2.
  - `save_done` is high during C3; `busy` is high from C1 through RELEASE.
  - Minimum capture-to-acknowledge latency is 3 cycles.
- Conv drops `valid` after sampling `save_done`. The next capture can occur no earlier than 2 cycles after `valid` falls: 1 cycle in RELEASE, then capture in IDLE.
- Read latency is 1: `rd_en` at edge N gives `rd_valid`=1 with data after edge N+1. `rd_valid` is a single-cycle pulse per request.
- A write to address A in WRITE, followed by a read of A after `busy` drops, returns the new value.
- Reset asserted mid-sequence:
  - Return to IDLE next edge with no `save_done`.
  - A write already completed in WRITE is kept.
  - `frame_done` is cleared.

## Test plan

- Single pixel: `first_chan`=1, `addr`=5, `out_pixel`=300, `shift`=0, `relu_en`=1, conv holds `valid` 6 cycles.
  - One `save_done` exactly 3 cycles after capture.
  - No second capture.
  - Reading addr 5 gives `rd_raw`=300 and `rd_data`=255 (saturated).
- Channel accumulation: addr 0 gets 100 with `first_chan`=1, then −40 and 25 with `first_chan`=0.
  - `rd_raw`=85.
  - `shift`=2 gives `rd_data`=21.
- Negative/ReLU: stored −500.
  - `relu_en`=1 gives `rd_data`=0.
  - `relu_en`=0 gives `rd_data`=0 and `rd_raw`=−500.
- Saturation: two adds of 2^23−1 on top of stored 2^27−100 → `rd_raw`=2^27−1.
- Full 13×14 frame (182 pixels, addr 0..181), with random pixels and the last one presented with `done`:
  - 182 `save_done` pulses.
  - `frame_done` set after the last WRITE.
  - All reads match the model.
  - `frame_clr` clears `frame_done`.
- Reset in READ:
  - No `save_done`, and the entry is unchanged.
  - `rd_en` during `busy` gives no `rd_valid`.

Source files
------------

// File: rtl/conv_collect.sv
// conv_collect: receiving side of the conv pixel handshake. Accumulates each
// channel's pixels into a local buffer and serves a requantized 8-bit read port.
module conv_collect #(
    parameter int ACC_W = 28,
    parameter int PIX_W = 24,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             done,
    input  logic [PIX_W-1:0] out_pixel,
    input  logic [7:0]       addr,
    input  logic             first_chan,
    input  logic             relu_en,
    input  logic [4:0]       shift,
    output logic             save_done,
    output logic             busy,
    output logic             frame_done,
    input  logic             frame_clr,
    input  logic             rd_en,
    input  logic [7:0]       rd_addr,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic [ACC_W-1:0] rd_raw
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_ACK,
        S_RELEASE
    } state_t;

    localparam logic signed [ACC_W:0] SAT_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [PIX_W-1:0]  pixel_q, pixel_d;
    logic [7:0]        addr_q, addr_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic [ACC_W-1:0]  stored_q, stored_d;
    logic              save_done_q, save_done_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              rd_valid_q, rd_valid_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [ACC_W-1:0]  rd_raw_q, rd_raw_d;

    logic                    wr_en;
    logic [ACC_W-1:0]        wr_data;
    logic signed [ACC_W:0]   pix_ext;
    logic signed [ACC_W:0]   stored_ext;
    logic signed [ACC_W:0]   sum_wide;
    logic signed [ACC_W-1:0] rq_in;
    logic signed [ACC_W-1:0] rq_relu;
    logic signed [ACC_W-1:0] rq_shift;
    logic [7:0]              rq_byte;

    // One guard bit above ACC_W lets the clamp see any overflow of the add.
    always_comb begin
        pix_ext    = {{(ACC_W+1-PIX_W){pixel_q[PIX_W-1]}}, pixel_q};
        stored_ext = {stored_q[ACC_W-1], stored_q};
        sum_wide   = first_q ? pix_ext : stored_ext + pix_ext;
        if (sum_wide > SAT_MAX) begin
            wr_data = {1'b0, {(ACC_W-1){1'b1}}};
        end else if (sum_wide < SAT_MIN) begin
            wr_data = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            wr_data = sum_wide[ACC_W-1:0];
        end
    end

    always_comb begin
        rq_in    = mem[rd_addr];
        rq_relu  = (relu_en && rq_in[ACC_W-1]) ? '0 : rq_in;
        rq_shift = rq_relu >>> shift;
        if (rq_shift[ACC_W-1]) begin
            rq_byte = 8'd0;
        end else if (|rq_shift[ACC_W-2:8]) begin
            rq_byte = 8'hFF;
        end else begin
            rq_byte = rq_shift[7:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        pixel_d      = pixel_q;
        addr_d       = addr_q;
        first_d      = first_q;
        last_d       = last_q;
        stored_d     = stored_q;
        save_done_d  = 1'b0;
        frame_done_d = frame_done_q;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        rd_raw_d     = rd_raw_q;

        if (frame_clr) begin
            frame_done_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (valid || done) begin
                    pixel_d = out_pixel;
                    addr_d  = addr;
                    first_d = first_chan;
                    last_d  = done;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                stored_d = mem[addr_q];
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                if (last_q) begin
                    frame_done_d = 1'b1;
                end
                save_done_d = 1'b1;
                state_d     = S_ACK;
            end
            S_ACK: begin
                state_d = S_RELEASE;
            end
            // Holding here until the conv lets go stops a held valid being captured twice.
            S_RELEASE: begin
                if (!valid && !done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);

        if (rd_en && !busy_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rq_byte;
            rd_raw_d   = rq_in;
        end
    end

    assign wr_en = (state_q == S_WRITE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pixel_q      <= '0;
            addr_q       <= '0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            stored_q     <= '0;
            save_done_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_raw_q     <= '0;
        end else begin
            state_q      <= state_d;
            pixel_q      <= pixel_d;
            addr_q       <= addr_d;
            first_q      <= first_d;
            last_q       <= last_d;
            stored_q     <= stored_d;
            save_done_q  <= save_done_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            rd_raw_q     <= rd_raw_d;
        end
    end

    // Buffer is deliberately left out of reset; the first channel overwrites it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr_q] <= wr_data;
        end
    end

    assign save_done  = save_done_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_raw     = rd_raw_q;

endmodule
